// File: rtl/mem_access_unit.sv
// Data-memory access unit for the MEM stage: issues one bus request per load/store,
// stalls the pipeline until ack or timeout, and formats load data for MEM/WB.
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        start_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] ALUResult_i,
  input  logic [31:0] RS2Data_i,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] RDData_o,
  output logic        stall_o,
  output logic        misalign_o,
  output logic        timeout_o
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] count, count_nx;
  logic [2:0]       f3_q, f3_nx;
  logic [1:0]       lane_q, lane_nx;
  logic             req_nx, we_nx, misalign_nx, timeout_nx;
  logic [31:0]      addr_nx, wdata_nx, rd_nx;
  logic [3:0]       be_nx;

  logic             access, is_store, misaligned;
  logic [31:0]      store_data;
  logic [3:0]       lane_be;

  // Load result: lane select by the saved address bits, sign or zero extend.
  function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [1:0] lane,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = lane[1] ? w[31:16] : w[15:0];
    case (f3[1:0])
      2'b00:   return f3[2] ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   return f3[2] ? {16'h0, h} : {{16{h[15]}}, h};
      default: return w;
    endcase
  endfunction

  assign access   = MemRead_i | MemWrite_i;
  assign is_store = MemWrite_i;

  always_comb begin
    misaligned = 1'b0;
    store_data = RS2Data_i;
    lane_be    = 4'b1111;
    case (funct3_i[1:0])
      2'b00: begin
        store_data = {4{RS2Data_i[7:0]}};
        lane_be    = 4'b0001 << ALUResult_i[1:0];
      end
      2'b01: begin
        misaligned = ALUResult_i[0];
        store_data = {2{RS2Data_i[15:0]}};
        lane_be    = ALUResult_i[1] ? 4'b1100 : 4'b0011;
      end
      default: misaligned = (ALUResult_i[1:0] != 2'b00);
    endcase
  end

  // Combinational stall; forced low while held in reset.
  assign stall_o = start_i & (((state == IDLE) & access & ~misaligned) | (state == REQ));

  always_comb begin
    state_nx    = state;
    count_nx    = count;
    f3_nx       = f3_q;
    lane_nx     = lane_q;
    req_nx      = mem_req_o;
    we_nx       = mem_we_o;
    addr_nx     = mem_addr_o;
    wdata_nx    = mem_wdata_o;
    be_nx       = mem_be_o;
    rd_nx       = RDData_o;
    misalign_nx = 1'b0;
    timeout_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (access) begin
          if (misaligned) begin
            misalign_nx = 1'b1;
            rd_nx       = 32'h0;
            state_nx    = DONE;
          end else begin
            req_nx   = 1'b1;
            we_nx    = is_store;
            addr_nx  = {ALUResult_i[31:2], 2'b00};
            wdata_nx = store_data;
            be_nx    = lane_be;
            f3_nx    = funct3_i;
            lane_nx  = ALUResult_i[1:0];
            count_nx = '0;
            state_nx = REQ;
          end
        end
      end
      REQ: begin
        if (mem_ack_i) begin
          req_nx = 1'b0;
          if (!mem_we_o) rd_nx = fmt_load(f3_q, lane_q, mem_rdata_i);
          state_nx = DONE;
        end else if (count == CNT_W'(TIMEOUT - 1)) begin
          req_nx     = 1'b0;
          rd_nx      = 32'h0;
          timeout_nx = 1'b1;
          state_nx   = DONE;
        end else begin
          count_nx = count + CNT_W'(1);
        end
      end
      // The frozen EX/MEM access is still presented here; leave without reissuing it.
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!start_i) begin
      state       <= IDLE;
      count       <= '0;
      f3_q        <= 3'b0;
      lane_q      <= 2'b0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= 32'h0;
      mem_wdata_o <= 32'h0;
      mem_be_o    <= 4'b0;
      RDData_o    <= 32'h0;
      misalign_o  <= 1'b0;
      timeout_o   <= 1'b0;
    end else begin
      state       <= state_nx;
      count       <= count_nx;
      f3_q        <= f3_nx;
      lane_q      <= lane_nx;
      mem_req_o   <= req_nx;
      mem_we_o    <= we_nx;
      mem_addr_o  <= addr_nx;
      mem_wdata_o <= wdata_nx;
      mem_be_o    <= be_nx;
      RDData_o    <= rd_nx;
      misalign_o  <= misalign_nx;
      timeout_o   <= timeout_nx;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: loads, stores, misalign, timeout and reset.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        start;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] alu, rs2;
  logic        ack;
  logic [31:0] rdata;
  logic        mem_req, mem_we, stall, misalign, timeout;
  logic [31:0] mem_addr, mem_wdata, rd_data;
  logic [3:0]  mem_be;

  int n_tests = 0;
  int n_fail  = 0;

  // Observations from the last transaction driven by do_access.
  int          req_cycles, stall_cycles;
  logic [31:0] cap_addr, cap_wdata, rd_done;
  logic [3:0]  cap_be;
  logic        cap_we, mis_done, to_done;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT(4)) dut (
    .clk_i(clk), .start_i(start), .MemRead_i(mem_read), .MemWrite_i(mem_write),
    .funct3_i(funct3), .ALUResult_i(alu), .RS2Data_i(rs2), .mem_ack_i(ack),
    .mem_rdata_i(rdata), .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_be_o(mem_be), .RDData_o(rd_data), .stall_o(stall),
    .misalign_o(misalign), .timeout_o(timeout)
  );

  // Presents one access, acks in REQ cycle ack_dly (0 = never), runs until DONE.
  task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input int ack_dly, input logic [31:0] rdat);
    int   cyc;
    logic done;
    req_cycles = 0; stall_cycles = 0; done = 1'b0; cyc = 0;
    @(negedge clk);
    mem_read = rd; mem_write = wr; funct3 = f3; alu = addr; rs2 = wd; ack = 1'b0;
    while (!done && cyc < 40) begin
      #1;
      if (cyc > 0 && !stall) begin
        done = 1'b1;
        rd_done = rd_data; mis_done = misalign; to_done = timeout;
      end else begin
        if (stall) stall_cycles++;
        if (mem_req) begin
          req_cycles++;
          if (req_cycles == 1) begin
            cap_addr = mem_addr; cap_wdata = mem_wdata; cap_be = mem_be; cap_we = mem_we;
          end
          if (req_cycles == ack_dly) begin ack = 1'b1; rdata = rdat; end
        end
        @(negedge clk);
        ack = 1'b0;
        cyc++;
      end
    end
    n_tests++;
    if (!done) begin n_fail++; $display("FAIL access_done: no DONE within %0d cycles", cyc); end
    mem_read = 1'b0; mem_write = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    start = 1'b0; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; alu = 32'h100;
    rs2 = 32'h0; ack = 1'b0; rdata = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    n_tests++;
    if ({mem_req, mem_we, mem_be, misalign, timeout} !== 8'h0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b required 0", {mem_req, mem_we, mem_be, misalign, timeout});
    end
    n_tests++;
    if ({mem_addr, mem_wdata, rd_data} !== 96'h0) begin
      n_fail++; $display("FAIL reset_data: got %h %h %h required 0", mem_addr, mem_wdata, rd_data);
    end
    n_tests++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b required 0", stall); end
    mem_read = 1'b0;
    start = 1'b1;
  endtask

  task automatic test_lw();
    do_access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 2, 32'hDEADBEEF);
    n_tests++;
    if (cap_addr !== 32'h100 || cap_be !== 4'b1111 || cap_we !== 1'b0) begin
      n_fail++; $display("FAIL lw_req: addr %h be %b we %b required 100 1111 0", cap_addr, cap_be, cap_we);
    end
    n_tests++;
    if (stall_cycles != 3 || req_cycles != 2) begin
      n_fail++; $display("FAIL lw_timing: stall %0d req %0d required 3 2", stall_cycles, req_cycles);
    end
    n_tests++;
    if (rd_done !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_data: got %h required deadbeef", rd_done); end
    do_access(1'b1, 1'b0, 3'b010, 32'h204, 32'h0, 1, 32'h11112222);
    n_tests++;
    if (stall_cycles != 2 || rd_done !== 32'h11112222) begin
      n_fail++; $display("FAIL lw_min_latency: stall %0d data %h required 2 11112222", stall_cycles, rd_done);
    end
  endtask

  task automatic test_sub_word_loads();
    do_access(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 1, 32'h80112233);
    n_tests++;
    if (rd_done !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb: got %h required ffffff80", rd_done); end
    do_access(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 1, 32'h80112233);
    n_tests++;
    if (rd_done !== 32'h00000080) begin n_fail++; $display("FAIL lbu: got %h required 00000080", rd_done); end
    do_access(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 1, 32'h80017FFF);
    n_tests++;
    if (rd_done !== 32'hFFFF8001) begin n_fail++; $display("FAIL lh_hi: got %h required ffff8001", rd_done); end
    do_access(1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 1, 32'h80017FFF);
    n_tests++;
    if (rd_done !== 32'h00008001) begin n_fail++; $display("FAIL lhu: got %h required 00008001", rd_done); end
    do_access(1'b1, 1'b0, 3'b001, 32'h100, 32'h0, 1, 32'h80017FFF);
    n_tests++;
    if (rd_done !== 32'h00007FFF) begin n_fail++; $display("FAIL lh_lo: got %h required 00007fff", rd_done); end
    do_access(1'b1, 1'b0, 3'b000, 32'h101, 32'h0, 1, 32'h0000A500);
    n_tests++;
    if (rd_done !== 32'hFFFFFFA5) begin n_fail++; $display("FAIL lb_lane1: got %h required ffffffa5", rd_done); end
  endtask

  task automatic test_stores();
    // RDData holds ffffffa5 from the previous load; stores must not touch it.
    do_access(1'b0, 1'b1, 3'b001, 32'h202, 32'h0000ABCD, 1, 32'h55555555);
    n_tests++;
    if (cap_we !== 1'b1 || cap_be !== 4'b1100 || cap_wdata !== 32'hABCDABCD || cap_addr !== 32'h200) begin
      n_fail++; $display("FAIL sh: we %b be %b wdata %h addr %h required 1 1100 abcdabcd 200",
                         cap_we, cap_be, cap_wdata, cap_addr);
    end
    n_tests++;
    if (rd_done !== 32'hFFFFFFA5) begin n_fail++; $display("FAIL sh_rd_hold: got %h required ffffffa5", rd_done); end
    do_access(1'b0, 1'b1, 3'b000, 32'h101, 32'h12345678, 1, 32'h0);
    n_tests++;
    if (cap_be !== 4'b0010 || cap_wdata !== 32'h78787878) begin
      n_fail++; $display("FAIL sb: be %b wdata %h required 0010 78787878", cap_be, cap_wdata);
    end
    // Both strobes set: the access is a store.
    do_access(1'b1, 1'b1, 3'b010, 32'h204, 32'hCAFEF00D, 1, 32'h0);
    n_tests++;
    if (cap_we !== 1'b1 || cap_be !== 4'b1111 || cap_wdata !== 32'hCAFEF00D || rd_done !== 32'hFFFFFFA5) begin
      n_fail++; $display("FAIL sw_both: we %b be %b wdata %h rd %h required 1 1111 cafef00d ffffffa5",
                         cap_we, cap_be, cap_wdata, rd_done);
    end
  endtask

  task automatic test_misalign();
    do_access(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 1, 32'h12345678);
    n_tests++;
    if (req_cycles != 0 || stall_cycles != 0 || mis_done !== 1'b1 || rd_done !== 32'h0) begin
      n_fail++; $display("FAIL misalign_lw: req %0d stall %0d mis %b rd %h required 0 0 1 0",
                         req_cycles, stall_cycles, mis_done, rd_done);
    end
    n_tests++;
    if (misalign !== 1'b0) begin n_fail++; $display("FAIL misalign_pulse: got %b required 0", misalign); end
    do_access(1'b0, 1'b1, 3'b001, 32'h203, 32'h0, 1, 32'h0);
    n_tests++;
    if (req_cycles != 0 || mis_done !== 1'b1) begin
      n_fail++; $display("FAIL misalign_sh: req %0d mis %b required 0 1", req_cycles, mis_done);
    end
  endtask

  task automatic test_ack_idle();
    @(negedge clk);
    ack = 1'b1; rdata = 32'h99999999;
    @(negedge clk);
    ack = 1'b0;
    #1;
    n_tests++;
    if (mem_req !== 1'b0 || rd_data !== 32'h0) begin
      n_fail++; $display("FAIL ack_idle: req %b rd %h required 0 0", mem_req, rd_data);
    end
  endtask

  task automatic test_reset_mid_req();
    do_access(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 1, 32'h13579BDF);
    @(negedge clk);
    mem_read = 1'b1; funct3 = 3'b010; alu = 32'h100;
    @(negedge clk);
    start = 1'b0;
    #1;
    n_tests++;
    if (mem_req !== 1'b1 || stall !== 1'b0) begin
      n_fail++; $display("FAIL rst_req_comb: req %b stall %b required 1 0", mem_req, stall);
    end
    @(negedge clk);
    start = 1'b1; mem_read = 1'b0;
    #1;
    n_tests++;
    if (mem_req !== 1'b0 || stall !== 1'b0 || mem_addr !== 32'h0 || mem_be !== 4'b0 || rd_data !== 32'h0) begin
      n_fail++; $display("FAIL rst_mid_req: req %b stall %b addr %h be %b rd %h required all 0",
                         mem_req, stall, mem_addr, mem_be, rd_data);
    end
    ack = 1'b1; rdata = 32'hFFFFFFFF;
    @(negedge clk);
    ack = 1'b0;
    #1;
    n_tests++;
    if (mem_req !== 1'b0 || rd_data !== 32'h0) begin
      n_fail++; $display("FAIL rst_late_ack: req %b rd %h required 0 0", mem_req, rd_data);
    end
  endtask

  task automatic test_timeout();
    do_access(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 1, 32'h2468ACE0);
    do_access(1'b1, 1'b0, 3'b010, 32'h404, 32'h0, 0, 32'h0);
    n_tests++;
    if (req_cycles != 4 || stall_cycles != 5) begin
      n_fail++; $display("FAIL timeout_len: req %0d stall %0d required 4 5", req_cycles, stall_cycles);
    end
    n_tests++;
    if (to_done !== 1'b1 || rd_done !== 32'h0) begin
      n_fail++; $display("FAIL timeout_result: pulse %b rd %h required 1 0", to_done, rd_done);
    end
    // Back in IDLE: pulse gone, and a new aligned access stalls immediately.
    mem_read = 1'b1; funct3 = 3'b010; alu = 32'h408;
    #1;
    n_tests++;
    if (timeout !== 1'b0 || stall !== 1'b1 || mem_req !== 1'b0) begin
      n_fail++; $display("FAIL timeout_idle: pulse %b stall %b req %b required 0 1 0", timeout, stall, mem_req);
    end
    mem_read = 1'b0;
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sub_word_loads();
    test_stores();
    test_misalign();
    test_ack_idle();
    test_reset_mid_req();
    test_timeout();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have port clk_i, input, 1: single clock; all state changes on its rising edge.
REQ-002 SHALL have port start_i, input, 1: reset, synchronous and active-low.
REQ-003 SHALL have port MemRead_i, input, 1: load access requested by the EX/MEM stage.
REQ-004 SHALL have port MemWrite_i, input, 1: store access requested by the EX/MEM stage.
REQ-005 SHALL have port funct3_i, input, 3: access size and sign (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-006 SHALL have port ALUResult_i, input, 32: byte address.
REQ-007 SHALL have port RS2Data_i, input, 32: store data.
REQ-008 SHALL have port mem_ack_i, input, 1: memory completion strobe.
REQ-009 SHALL have port mem_rdata_i, input, 32: memory read word, valid with mem_ack_i.
REQ-010 SHALL have port mem_req_o, output, 1: registered request, held until ack or timeout.
REQ-011 SHALL have port mem_we_o, output, 1: registered; 1 = store.
REQ-012 SHALL have port mem_addr_o, output, 32: registered word address, ALUResult_i with bits [1:0] = 00.
REQ-013 SHALL have port mem_wdata_o, output, 32: registered lane-replicated store data.
REQ-014 SHALL have port mem_be_o, output, 4: registered byte enables.
REQ-015 SHALL have port RDData_o, output, 32: registered, formatted load result for the MEM_WB register.
REQ-016 SHALL have port stall_o, output, 1: combinational; freezes PC, IF/ID, ID/EX and EX/MEM.
REQ-017 SHALL have port misalign_o, output, 1: registered one-cycle pulse.
REQ-018 SHALL have port timeout_o, output, 1: registered one-cycle pulse.
REQ-019 SHALL have parameter TIMEOUT, default 255: maximum number of cycles spent in REQ.

Function
REQ-020 SHALL implement the FSM states IDLE, REQ and DONE.
REQ-021 SHALL define access = MemRead_i | MemWrite_i; when both inputs are 1, the access is a store.
REQ-022 SHALL treat an access as misaligned when H/HU has addr[0]=1, or W has addr[1:0]!=00.
REQ-023 IDLE with an aligned access SHALL go to REQ at the next edge, with mem_req_o=1, mem_we_o, mem_addr_o, mem_wdata_o and mem_be_o loaded, and the counter cleared.
REQ-024 IDLE with a misaligned access SHALL issue no request, SHALL pulse misalign_o for 1 cycle, SHALL set RDData_o=0, and SHALL go to DONE.
REQ-025 stall_o SHALL equal (IDLE & aligned access) | REQ; it SHALL be 0 in DONE.
REQ-026 REQ with mem_ack_i=1 SHALL drop mem_req_o, capture the formatted load into RDData_o (stores leave RDData_o unchanged), and go to DONE.
REQ-027 In REQ the counter SHALL increment each cycle without ack; when count reaches TIMEOUT-1 with no ack, it SHALL drop mem_req_o, set RDData_o=0, pulse timeout_o, and go to DONE.
REQ-028 DONE SHALL return to IDLE unconditionally, so the held EX/MEM access is not reissued; access inputs are ignored in DONE.
REQ-029 mem_ack_i SHALL be ignored in IDLE and DONE.
REQ-030 Store byte enables SHALL be: SB 0001<<addr[1:0], SH 0011<<{addr[1],0}, SW 1111.
REQ-031 Store data SHALL be: SB byte x4, SH halfword x2, SW unchanged.
REQ-032 Load formatting SHALL select the lane by addr[1:0]; B/H sign-extend, BU/HU zero-extend, W passes through.
REQ-033 Minimum latency SHALL be 3 cycles for an aligned access with ack in the first REQ cycle: 2 stall cycles, then DONE.

Reset
REQ-034 start_i=0 at an edge SHALL force IDLE, clear the counter, and set every registered output to 0, including mid-REQ (mem_req_o drops at that edge).
REQ-035 While start_i=0, stall_o SHALL be 0.

Verification
REQ-036 LW addr 0x100 with ack after 2 cycles and rdata 0xDEADBEEF -> mem_addr_o=0x100, be=1111, stall_o high 3 cycles, RDData_o=0xDEADBEEF.
REQ-037 LB addr 0x103 with rdata 0x80112233 -> RDData_o=0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-038 SH addr 0x202 with RS2Data 0x0000ABCD -> mem_we_o=1, be=1100, wdata=0xABCDABCD, RDData_o unchanged.
REQ-039 LW addr 0x101 -> no mem_req_o, misalign_o 1-cycle pulse, stall_o=0, RDData_o=0.
REQ-040 Aligned load with no ack, TIMEOUT=4 -> mem_req_o high 4 cycles, timeout_o pulse, RDData_o=0, FSM back in IDLE 2 cycles later.
REQ-041 start_i=0 during REQ -> next edge mem_req_o=0, stall_o=0, all outputs 0; a later ack is ignored.
